// File: rtl/rmii_rx_deframer_if.sv
// RX FIFO write-side bus of the RMII receive deframer.
//   master : the deframer; drives the write strobe, data byte and EOD/ERR tags, observes fifo_full
//   slave  : the FIFO; accepts writes, reports fifo_full
// Signals:
//   fifo_full    FIFO cannot accept a byte; writes are ignored while high
//   fifo_wren    one-cycle write strobe per byte
//   fifo_din     byte to write
//   fifo_EOD_in  byte is the last of its frame
//   fifo_ERR_in  frame is bad (meaningful only with fifo_EOD_in=1)
interface rmii_rx_deframer_if;
  logic       fifo_full;
  logic       fifo_wren;
  logic [7:0] fifo_din;
  logic       fifo_EOD_in;
  logic       fifo_ERR_in;

  modport master (
    input  fifo_full,
    output fifo_wren,
    output fifo_din,
    output fifo_EOD_in,
    output fifo_ERR_in
  );

  modport slave (
    output fifo_full,
    input  fifo_wren,
    input  fifo_din,
    input  fifo_EOD_in,
    input  fifo_ERR_in
  );
endinterface

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer.
// Samples RXD[1:0]/CRS_DV on REF_CLK, strips preamble and SFD, assembles body bytes LSB dibit first
// and writes them to the RX FIFO one byte behind the line, so the final byte of a frame can be
// tagged EOD (and ERR) once the carrier drops. Good and bad frames are counted in 16-bit binary
// counters exported gray coded for a consumer in another clock domain.
//
// Optional feature: define RMII_RX_FCS_CHECK_EN to check the CRC-32 FCS of every frame; a frame
// whose residue is wrong is tagged ERR on its EOD byte and counted as bad. Without it the FCS bytes
// are passed through unchecked.
//
// Ports:
//   REF_CLK             50 MHz RMII reference clock
//   arst_n              asynchronous active-low reset
//   RXD0, RXD1          receive dibit, RXD0 is the lower bit
//   CRS_DV              carrier sense / data valid
//   fifo                FIFO write bus (master side), all outputs registered
//   succ_rx_count_gray  good-frame counter, gray coded
//   fail_rx_count_gray  bad-frame counter, gray coded
module rmii_rx_deframer #(
  parameter int unsigned MIN_PRE   = 8,
  parameter int unsigned MAX_BYTES = 1522
) (
  input  logic                       REF_CLK,
  input  logic                       arst_n,
  input  logic                       RXD0,
  input  logic                       RXD1,
  input  logic                       CRS_DV,
  rmii_rx_deframer_if.master         fifo,
  output logic [15:0]                succ_rx_count_gray,
  output logic [15:0]                fail_rx_count_gray
);

  localparam int unsigned       CntW   = $clog2(MAX_BYTES + 2);
  localparam logic [CntW-1:0]   MaxCnt = CntW'(MAX_BYTES + 1);
  localparam logic [7:0]        MinPre = 8'(MIN_PRE);

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StBody,
    StDrop,
    StFlush
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      pre_q, pre_d;
  logic [1:0]      dibit_q, dibit_d;
  logic [5:0]      sr_q, sr_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_vld_q, buf_vld_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic            wr_any_q, wr_any_d;
  logic            fresh_q, fresh_d;

  logic            wren_q, wren_d;
  logic [7:0]      din_q, din_d;
  logic            eod_q, eod_d;
  logic            err_q, err_d;

  logic [15:0]     succ_q, fail_q;
  logic [15:0]     succ_gray_q, fail_gray_q;
  logic            succ_inc, fail_inc;

  logic [1:0]      rxd;
  logic [7:0]      byte_new;
  logic [CntW-1:0] byte_cnt_nx;
  logic            fcs_bad;

  assign rxd         = {RXD1, RXD0};
  assign byte_new    = {rxd, sr_q};
  assign byte_cnt_nx = byte_cnt_q + 1'b1;

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_rev;
  logic        crc_clr, crc_upd;

  // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit reversed), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (crc_clr) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (crc_upd) begin
      crc_q <= crc32_byte(crc_q, byte_new);
    end
  end

  // The register runs reflected; compare its bit-reversed view against the standard residue.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      crc_rev[i] = crc_q[31-i];
    end
  end

  assign fcs_bad = (crc_rev != 32'hC704DD7B);
`else
  assign fcs_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    dibit_d    = dibit_q;
    sr_d       = sr_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    byte_cnt_d = byte_cnt_q;
    wr_any_d   = wr_any_q;
    fresh_d    = fresh_q;
    wren_d     = 1'b0;
    din_d      = 8'h00;
    eod_d      = 1'b0;
    err_d      = 1'b0;
    succ_inc   = 1'b0;
    fail_inc   = 1'b0;
`ifdef RMII_RX_FCS_CHECK_EN
    crc_clr    = 1'b0;
    crc_upd    = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        wr_any_d = 1'b0;
        if (CRS_DV) begin
          if (fresh_q) begin
            // Carrier already up when we left reset: ride out the rest of that frame.
            state_d = StDrop;
          end else begin
            state_d = StPreamble;
            pre_d   = {7'd0, rxd == 2'b01};
          end
        end else begin
          fresh_d = 1'b0;
        end
      end

      StPreamble: begin
        if (!CRS_DV) begin
          state_d = StIdle;
        end else begin
          case (rxd)
            2'b01: if (pre_q != 8'hFF) pre_d = pre_q + 8'd1;
            2'b00: ;
            2'b11: begin
              if (pre_q >= MinPre) begin
                state_d    = StBody;
                dibit_d    = 2'd0;
                buf_vld_d  = 1'b0;
                byte_cnt_d = '0;
`ifdef RMII_RX_FCS_CHECK_EN
                crc_clr    = 1'b1;
`endif
              end else begin
                state_d = StDrop;
              end
            end
            default: state_d = StDrop;
          endcase
        end
      end

      StBody: begin
        if (!CRS_DV) begin
          if (!buf_vld_q) begin
            // Carrier dropped before any complete byte.
            fail_inc = 1'b1;
            state_d  = StIdle;
          end else if (fifo.fifo_full) begin
            // Final byte cannot be written: same handling as an overflow.
            fail_inc = 1'b1;
            state_d  = wr_any_q ? StFlush : StIdle;
          end else begin
            wren_d  = 1'b1;
            din_d   = buf_q;
            eod_d   = 1'b1;
            err_d   = (dibit_q != 2'd0) || fcs_bad;
            succ_inc = !err_d;
            fail_inc = err_d;
            state_d = StIdle;
          end
        end else begin
          dibit_d = dibit_q + 2'd1;
          sr_d    = {rxd, sr_q[5:2]};
          if (dibit_q == 2'd3) begin
            byte_cnt_d = byte_cnt_nx;
            if (byte_cnt_nx == MaxCnt) begin
              fail_inc = 1'b1;
              state_d  = StDrop;
            end else if (buf_vld_q && fifo.fifo_full) begin
              // Byte is discarded rather than strobed into a full FIFO.
              fail_inc = 1'b1;
              state_d  = StDrop;
            end else begin
              if (buf_vld_q) begin
                wren_d   = 1'b1;
                din_d    = buf_q;
                wr_any_d = 1'b1;
              end
              buf_d     = byte_new;
              buf_vld_d = 1'b1;
`ifdef RMII_RX_FCS_CHECK_EN
              crc_upd   = 1'b1;
`endif
            end
          end
        end
      end

      StDrop: begin
        if (!CRS_DV) begin
          // A frame with bytes already in the FIFO must be closed with an error marker.
          state_d = wr_any_q ? StFlush : StIdle;
        end
      end

      StFlush: begin
        if (!fifo.fifo_full) begin
          wren_d  = 1'b1;
          din_d   = 8'h00;
          eod_d   = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      pre_q      <= 8'd0;
      dibit_q    <= 2'd0;
      sr_q       <= 6'd0;
      buf_q      <= 8'd0;
      buf_vld_q  <= 1'b0;
      byte_cnt_q <= '0;
      wr_any_q   <= 1'b0;
      fresh_q    <= 1'b1;
      wren_q     <= 1'b0;
      din_q      <= 8'd0;
      eod_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      dibit_q    <= dibit_d;
      sr_q       <= sr_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      byte_cnt_q <= byte_cnt_d;
      wr_any_q   <= wr_any_d;
      fresh_q    <= fresh_d;
      wren_q     <= wren_d;
      din_q      <= din_d;
      eod_q      <= eod_d;
      err_q      <= err_d;
    end
  end

  // Binary counters wrap naturally; the gray copies are registered so the exported value never
  // shows a combinational glitch to the other clock domain.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      succ_q      <= 16'd0;
      fail_q      <= 16'd0;
      succ_gray_q <= 16'd0;
      fail_gray_q <= 16'd0;
    end else begin
      if (succ_inc) succ_q <= succ_q + 16'd1;
      if (fail_inc) fail_q <= fail_q + 16'd1;
      succ_gray_q <= succ_q ^ (succ_q >> 1);
      fail_gray_q <= fail_q ^ (fail_q >> 1);
    end
  end

  assign fifo.fifo_wren      = wren_q;
  assign fifo.fifo_din       = din_q;
  assign fifo.fifo_EOD_in    = eod_q;
  assign fifo.fifo_ERR_in    = err_q;
  assign succ_rx_count_gray  = succ_gray_q;
  assign fail_rx_count_gray  = fail_gray_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
module tb_rmii_rx_deframer;

`ifdef RMII_RX_FCS_CHECK_EN
  localparam bit FcsOn = 1'b1;
`else
  localparam bit FcsOn = 1'b0;
`endif

  logic        REF_CLK = 1'b0;
  logic        arst_n  = 1'b0;
  logic        RXD0    = 1'b0;
  logic        RXD1    = 1'b0;
  logic        CRS_DV  = 1'b0;
  logic [15:0] succ_gray;
  logic [15:0] fail_gray;

  rmii_rx_deframer_if bus ();

  rmii_rx_deframer #(
    .MIN_PRE   (8),
    .MAX_BYTES (1522)
  ) dut (
    .REF_CLK            (REF_CLK),
    .arst_n             (arst_n),
    .RXD0               (RXD0),
    .RXD1               (RXD1),
    .CRS_DV             (CRS_DV),
    .fifo               (bus.master),
    .succ_rx_count_gray (succ_gray),
    .fail_rx_count_gray (fail_gray)
  );

  always #10 REF_CLK = ~REF_CLK;

  int         total = 0;
  int         bad   = 0;
  logic [9:0] exp_q[$];
  logic [7:0] body [0:1599];
  int         full_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Scoreboard: every FIFO write is popped against the next expected {din, EOD, ERR}.
  always @(negedge REF_CLK) begin
    if (bus.fifo_wren === 1'b1) begin
      chk("write_queued", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("fifo_write", {22'd0, bus.fifo_din, bus.fifo_EOD_in, bus.fifo_ERR_in}, {22'd0, e});
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic eod, input logic err);
    exp_q.push_back({d, eod, err});
  endtask

  task automatic push_body(input int first, input int last);
    for (int i = first; i <= last; i++) push(body[i], 1'b0, 1'b0);
  endtask

  task automatic fill_body();
    for (int i = 0; i < 1600; i++) body[i] = 8'($urandom);
  endtask

  task automatic drive(input logic [1:0] d, input logic dv);
    @(negedge REF_CLK);
    RXD0   = d[0];
    RXD1   = d[1];
    CRS_DV = dv;
    if (full_left > 0) begin
      bus.fifo_full = 1'b1;
      full_left--;
    end else begin
      bus.fifo_full = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 1'b0);
  endtask

  // pre01 x "01" dibits, one SFD dibit, nbytes body bytes, tail dibits of a partial byte, then
  // carrier off. full_byte / rst_byte (1-based, 0 = none) start an 8-cycle FIFO-full window or a
  // reset pulse at the first dibit of that byte.
  task automatic send_frame(input int pre01, input logic [1:0] sfd, input int nbytes,
                            input int tail, input int full_byte, input int rst_byte);
    logic [7:0] b;
    for (int i = 0; i < pre01; i++) drive(2'b01, 1'b1);
    drive(sfd, 1'b1);
    for (int i = 0; i < nbytes; i++) begin
      b = body[i];
      if (i + 1 == full_byte) full_left = 8;
      for (int n = 0; n < 4; n++) begin
        drive(b[2*n +: 2], 1'b1);
        if (i + 1 == rst_byte && n == 0) begin
          #2 arst_n = 1'b0;
          #3 arst_n = 1'b1;
        end
      end
    end
    b = body[nbytes];
    for (int n = 0; n < tail; n++) drive(b[2*n +: 2], 1'b1);
    idle(8);
  endtask

  task automatic do_reset(input string tag);
    @(negedge REF_CLK);
    arst_n = 1'b0;
    #1;
    chk({tag, "_rst_wren"}, {31'd0, bus.fifo_wren}, 32'd0);
    chk({tag, "_rst_din"}, {24'd0, bus.fifo_din}, 32'd0);
    chk({tag, "_rst_tags"}, {30'd0, bus.fifo_EOD_in, bus.fifo_ERR_in}, 32'd0);
    chk({tag, "_rst_succ"}, {16'd0, succ_gray}, 32'd0);
    chk({tag, "_rst_fail"}, {16'd0, fail_gray}, 32'd0);
    exp_q.delete();
    @(negedge REF_CLK);
    arst_n = 1'b1;
    idle(2);
  endtask

  task automatic check_end(input string tag, input logic [15:0] s, input logic [15:0] f);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
    chk({tag, "_succ_gray"}, {16'd0, succ_gray}, {16'd0, gray(s)});
    chk({tag, "_fail_gray"}, {16'd0, fail_gray}, {16'd0, gray(f)});
  endtask

  initial begin
    logic [31:0] crc;
    bus.fifo_full = 1'b0;
    repeat (3) @(negedge REF_CLK);

    // 1) clean 64-byte frame behind a 7x55+D5 preamble
    do_reset("t1");
    fill_body();
    push_body(0, 62);
    push(body[63], 1'b1, 1'b0);
    send_frame(31, 2'b11, 64, 0, 0, 0);
    check_end("t1", 16'd1, 16'd0);

    // 2) FIFO full across byte 21 completion, then a clean frame
    do_reset("t2");
    fill_body();
    push_body(0, 18);
    push(8'h00, 1'b1, 1'b1);
    send_frame(31, 2'b11, 64, 0, 21, 0);
    check_end("t2a", 16'd0, 16'd1);
    push_body(0, 62);
    push(body[63], 1'b1, 1'b0);
    send_frame(31, 2'b11, 64, 0, 0, 0);
    check_end("t2b", 16'd1, 16'd1);

    // 3) carrier lost two dibits into byte 10
    do_reset("t3");
    fill_body();
    push_body(0, 7);
    push(body[8], 1'b1, 1'b1);
    send_frame(31, 2'b11, 9, 2, 0, 0);
    check_end("t3", 16'd0, 16'd1);

    // 4) preamble boundaries and false carrier
    do_reset("t4");
    fill_body();
    send_frame(3, 2'b11, 40, 0, 0, 0);
    check_end("t4_short", 16'd0, 16'd0);
    send_frame(7, 2'b11, 8, 0, 0, 0);
    check_end("t4_pre7", 16'd0, 16'd0);
    push_body(0, 2);
    push(body[3], 1'b1, 1'b0);
    send_frame(8, 2'b11, 4, 0, 0, 0);
    check_end("t4_pre8", 16'd1, 16'd0);
    send_frame(10, 2'b10, 8, 0, 0, 0);
    check_end("t4_dibit10", 16'd1, 16'd0);
    send_frame(31, 2'b11, 0, 2, 0, 0);
    check_end("t4_nobyte", 16'd1, 16'd1);

    // 5) frame with correct FCS, then the same frame with one payload bit flipped
    do_reset("t5");
    fill_body();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) crc = crc_next(crc, body[i]);
    crc = ~crc;
    for (int j = 0; j < 4; j++) body[60+j] = crc[8*j +: 8];
    push_body(0, 62);
    push(body[63], 1'b1, 1'b0);
    send_frame(31, 2'b11, 64, 0, 0, 0);
    check_end("t5_good", 16'd1, 16'd0);
    body[5] = body[5] ^ 8'h10;
    push_body(0, 62);
    push(body[63], 1'b1, FcsOn);
    send_frame(31, 2'b11, 64, 0, 0, 0);
    check_end("t5_flip", FcsOn ? 16'd1 : 16'd2, FcsOn ? 16'd1 : 16'd0);

    // 6) reset pulse at byte 30, remainder ignored, next frame clean
    do_reset("t6");
    fill_body();
    push_body(0, 27);
    send_frame(31, 2'b11, 64, 0, 0, 30);
    chk("t6_wren_after", {31'd0, bus.fifo_wren}, 32'd0);
    check_end("t6a", 16'd0, 16'd0);
    push_body(0, 62);
    push(body[63], 1'b1, 1'b0);
    send_frame(31, 2'b11, 64, 0, 0, 0);
    check_end("t6b", 16'd1, 16'd0);

    // 7) length limit: exactly MAX_BYTES passes, one more is dropped and flushed
    do_reset("t7");
    fill_body();
    push_body(0, 1520);
    push(body[1521], 1'b1, 1'b0);
    send_frame(31, 2'b11, 1522, 0, 0, 0);
    check_end("t7_max", 16'd1, 16'd0);
    push_body(0, 1520);
    push(8'h00, 1'b1, 1'b1);
    send_frame(31, 2'b11, 1523, 0, 0, 0);
    check_end("t7_over", 16'd1, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
